// File: rtl/dram_cycle_arbiter.sv
// DRAM access sequencer: arbitrates refresh, video fetch and CPU cycles onto a shared
// multiplexed-address DRAM and drives RAS/CAS/WE, the address mux and the data strobes.
module dram_cycle_arbiter #(
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter logic [13:0] SCREEN_BASE    = 14'h2000
) (
  input  logic        PIN_CLK,
  input  logic        PIN_R,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [13:0] cpu_addr,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic        vid_frame,
  input  logic [7:0]  scroll,
  output logic [6:0]  dram_a,
  output logic        dram_ras_n,
  output logic [1:0]  dram_cas_n,
  output logic        dram_we_n,
  output logic        lat_en,
  output logic        vid_load,
  output logic        vid_ovr
);

  localparam int unsigned TW = $clog2(REFRESH_PERIOD);

  typedef enum logic [2:0] {StIdle, StRow, StRas, StCol, StCas, StPre} state_e;
  typedef enum logic [1:0] {KindRef, KindVid, KindCpu} kind_e;

  state_e        state;
  kind_e         kind;
  logic [TW-1:0] ref_timer;
  logic          ref_pend;
  logic          vid_pend;
  logic [6:0]    ref_row;
  logic [7:0]    vid_line;
  logic [4:0]    vid_word;
  logic [13:0]   addr;
  logic          we_l;
  logic [1:0]    be_l;

  logic          ref_wrap;
  logic          vid_busy;
  logic          vid_overrun;
  logic          ref_hit;
  logic          vid_hit;
  logic          vid_step;
  logic [7:0]    line_sum;
  logic [13:0]   vid_addr;
  logic          grant;
  kind_e         grant_kind;
  logic [13:0]   grant_addr;

  always_comb begin
    ref_wrap    = (ref_timer == TW'(REFRESH_PERIOD - 1));
    vid_busy    = (kind == KindVid) && (state inside {StRow, StRas, StCol, StCas});
    vid_overrun = vid_req && (vid_pend || vid_busy);
    // Requests arriving on the arbitration clock itself take part in that decision.
    ref_hit     = ref_pend || ref_wrap;
    vid_hit     = vid_pend || (vid_req && !vid_busy);
    vid_step    = (state == StCas) && (kind == KindVid);
    line_sum    = vid_line + scroll;
    vid_addr    = SCREEN_BASE + {1'b0, line_sum, vid_word};

    grant      = 1'b1;
    grant_kind = KindCpu;
    grant_addr = cpu_addr;
    if (ref_hit) begin
      grant_kind = KindRef;
      grant_addr = {7'b0, ref_row};
    end else if (vid_hit) begin
      grant_kind = KindVid;
      grant_addr = vid_addr;
    end else if (!cpu_req) begin
      grant = 1'b0;
    end
  end

  always_ff @(posedge PIN_CLK or posedge PIN_R) begin
    if (PIN_R) begin
      state      <= StIdle;
      kind       <= KindRef;
      ref_timer  <= '0;
      ref_pend   <= 1'b0;
      vid_pend   <= 1'b0;
      ref_row    <= '0;
      vid_line   <= '0;
      vid_word   <= '0;
      addr       <= '0;
      we_l       <= 1'b0;
      be_l       <= 2'b00;
      dram_a     <= '0;
      dram_ras_n <= 1'b1;
      dram_cas_n <= 2'b11;
      dram_we_n  <= 1'b1;
      cpu_ack    <= 1'b0;
      lat_en     <= 1'b0;
      vid_load   <= 1'b0;
      vid_ovr    <= 1'b0;
    end else begin
      ref_timer <= ref_wrap ? '0 : ref_timer + TW'(1);
      if (ref_wrap) ref_pend <= 1'b1;
      // A request that collides with an in-flight video cycle is dropped, not queued.
      if (vid_req && !vid_busy) vid_pend <= 1'b1;

      if (vid_frame) begin
        vid_ovr <= 1'b0;
      end else if (vid_overrun) begin
        vid_ovr <= 1'b1;
      end

      if (vid_frame) begin
        vid_line <= '0;
        vid_word <= '0;
      end else if (vid_step) begin
        vid_word <= vid_word + 5'd1;
        if (vid_word == 5'd31) vid_line <= vid_line + 8'd1;
      end

      cpu_ack  <= 1'b0;
      lat_en   <= 1'b0;
      vid_load <= 1'b0;

      unique case (state)
        StIdle: begin
          if (grant) begin
            state  <= StRow;
            kind   <= grant_kind;
            addr   <= grant_addr;
            we_l   <= cpu_we;
            be_l   <= cpu_be;
            dram_a <= grant_addr[6:0];
            if (grant_kind == KindRef) ref_pend <= 1'b0;
            if (grant_kind == KindVid) vid_pend <= 1'b0;
          end
        end
        StRow: begin
          state      <= StRas;
          dram_ras_n <= 1'b0;
        end
        StRas: begin
          state     <= StCol;
          dram_a    <= addr[13:7];
          dram_we_n <= (kind == KindCpu) ? ~we_l : 1'b1;
        end
        StCol: begin
          state <= StCas;
          if (kind == KindRef) begin
            dram_cas_n <= 2'b11;
          end else if (kind == KindCpu && we_l) begin
            dram_cas_n <= ~be_l;
          end else begin
            dram_cas_n <= 2'b00;
          end
        end
        StCas: begin
          state      <= StPre;
          dram_ras_n <= 1'b1;
          dram_cas_n <= 2'b11;
          dram_we_n  <= 1'b1;
          lat_en     <= (kind == KindCpu) && !we_l;
          vid_load   <= (kind == KindVid);
          cpu_ack    <= (kind == KindCpu);
          if (kind == KindRef) ref_row <= ref_row + 7'd1;
        end
        StPre: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cycle_arbiter.sv
// Bench for dram_cycle_arbiter: a pin monitor decodes each DRAM access into a transaction,
// which directed and randomized steps compare against addresses derived from the access rules.
module tb_dram_cycle_arbiter;

  localparam int unsigned RP   = 64;
  localparam logic [13:0] BASE = 14'h2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, vid_req, vid_frame;
  logic [1:0]  cpu_be;
  logic [13:0] cpu_addr;
  logic [7:0]  scroll;
  logic        cpu_ack, dram_ras_n, dram_we_n, lat_en, vid_load, vid_ovr;
  logic [1:0]  dram_cas_n;
  logic [6:0]  dram_a;

  always #5 clk = ~clk;

  dram_cycle_arbiter #(
    .REFRESH_PERIOD (RP),
    .SCREEN_BASE    (BASE)
  ) dut (
    .PIN_CLK    (clk),
    .PIN_R      (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_ack    (cpu_ack),
    .vid_req    (vid_req),
    .vid_frame  (vid_frame),
    .scroll     (scroll),
    .dram_a     (dram_a),
    .dram_ras_n (dram_ras_n),
    .dram_cas_n (dram_cas_n),
    .dram_we_n  (dram_we_n),
    .lat_en     (lat_en),
    .vid_load   (vid_load),
    .vid_ovr    (vid_ovr)
  );

  typedef struct packed {
    logic [6:0] row_pre;
    logic [6:0] row;
    logic [6:0] col;
    logic [6:0] col_cas;
    logic       we_col;
    logic       we_cas;
    logic [1:0] cas;
    logic       lat;
    logic       load;
    logic       ack;
    logic       pre_idle;
  } txn_t;

  txn_t txq[$];
  int   tests = 0;
  int   fails = 0;
  int   ack_cnt = 0;
  int   load_cnt = 0;
  int   cyc = 0;
  logic [6:0] exp_ref = '0;
  logic [7:0] m_line = '0;
  logic [4:0] m_word = '0;

  // Clocks since reset release: refresh requests fall on every RP-th edge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Pin monitor: RAS falling marks an access; COL, CAS and PRE follow on successive clocks.
  initial begin
    int   mon_k;
    logic prev_ras;
    logic [6:0] prev_a;
    txn_t cur;
    mon_k = -1;
    prev_ras = 1'b1;
    prev_a = '0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (cpu_ack)  ack_cnt++;
      if (vid_load) load_cnt++;
      if (rst) begin
        mon_k = -1;
        prev_ras = 1'b1;
      end else begin
        if (prev_ras && !dram_ras_n) begin
          cur = '0;
          cur.row_pre = prev_a;
          cur.row = dram_a;
          mon_k = 0;
        end else if (mon_k == 0) begin
          cur.col = dram_a;
          cur.we_col = dram_we_n;
          mon_k = 1;
        end else if (mon_k == 1) begin
          cur.col_cas = dram_a;
          cur.we_cas = dram_we_n;
          cur.cas = dram_cas_n;
          mon_k = 2;
        end else if (mon_k == 2) begin
          cur.lat = lat_en;
          cur.load = vid_load;
          cur.ack = cpu_ack;
          cur.pre_idle = dram_ras_n && (dram_cas_n == 2'b11) && dram_we_n;
          txq.push_back(cur);
          mon_k = -1;
        end
        prev_ras = dram_ras_n;
        prev_a = dram_a;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ref(input txn_t t);
    chk("refresh", {t.row_pre, t.row, t.col, t.cas, t.we_col, t.we_cas, t.lat, t.load, t.ack,
                    t.pre_idle},
        {exp_ref, exp_ref, 7'h00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_ref = exp_ref + 7'd1;
  endtask

  task automatic check_cpu(input string tag, input txn_t t, input logic [13:0] a,
                           input logic we, input logic [1:0] be);
    logic [1:0] ecas;
    ecas = we ? ~be : 2'b00;
    chk(tag, {t.row_pre, t.row, t.col, t.col_cas, t.we_col, t.we_cas, t.cas, t.lat, t.load,
              t.ack, t.pre_idle},
        {a[6:0], a[6:0], a[13:7], a[13:7], ~we, ~we, ecas, ~we, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic check_vid(input string tag, input txn_t t, output logic [13:0] a);
    logic [7:0] l;
    l = m_line + scroll;
    a = BASE + {1'b0, l, m_word};
    chk(tag, {t.row_pre, t.row, t.col, t.col_cas, t.we_col, t.we_cas, t.cas, t.lat, t.load,
              t.ack, t.pre_idle},
        {a[6:0], a[6:0], a[13:7], a[13:7], 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1});
    m_word = m_word + 5'd1;
    if (m_word == 5'd0) m_line = m_line + 8'd1;
  endtask

  // Next CPU or video transaction; refreshes met on the way are checked and skipped.
  task automatic get_txn(output txn_t t);
    int  n;
    bit  found;
    n = 0;
    found = 0;
    t = '0;
    while (!found) begin
      while (txq.size() == 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (txq.size() == 0) begin
        chk("txn_timeout", 64'd0, 64'd1);
        return;
      end
      t = txq.pop_front();
      if (!t.ack && !t.load) check_ref(t);
      else found = 1;
    end
  endtask

  task automatic drain();
    txn_t t;
    while (txq.size() > 0) begin
      t = txq.pop_front();
      if (!t.ack && !t.load) check_ref(t);
      else chk("stray_txn", {t.ack, t.load}, 2'b00);
    end
  endtask

  task automatic cpu_access(input logic [13:0] a, input logic we, input logic [1:0] be,
                            input bit with_vid, output int lat);
    cpu_addr = a;
    cpu_we = we;
    cpu_be = be;
    cpu_req = 1'b1;
    vid_req = with_vid;
    lat = 0;
    while (!cpu_ack && lat < 60) begin
      @(negedge clk);
      vid_req = 1'b0;
      lat++;
    end
    if (!cpu_ack) chk("ack_timeout", 64'd0, 64'd1);
    cpu_req = 1'b0;
  endtask

  task automatic pulse_vid();
    vid_req = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
  endtask

  task automatic pulse_frame();
    vid_frame = 1'b1;
    @(negedge clk);
    vid_frame = 1'b0;
    m_line = '0;
    m_word = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t        t;
    txn_t        t1;
    txn_t        t2;
    int          lat;
    int          n;
    int          c0;
    logic [13:0] a;
    logic [13:0] va;
    logic        we;
    logic [1:0]  be;
    bit          wv;

    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_be = 2'b00;
    cpu_addr = '0;
    vid_req = 1'b0;
    vid_frame = 1'b0;
    scroll = 8'h00;
    #1;
    chk("reset_outputs", {dram_ras_n, dram_cas_n, dram_we_n, dram_a, cpu_ack, lat_en, vid_load,
                          vid_ovr},
        {1'b1, 2'b11, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // CPU read alone.
    cpu_access(14'h1234, 1'b0, 2'b00, 1'b0, lat);
    chk("read_latency", lat, 5);
    chk("read_ack_with_lat", {cpu_ack, lat_en}, 2'b11);
    get_txn(t);
    check_cpu("read_1234", t, 14'h1234, 1'b0, 2'b00);
    chk("read_1234_row_col", {t.row, t.col}, {7'h34, 7'h24});

    // CPU write to the high bank only.
    @(negedge clk);
    cpu_access(14'h0000, 1'b1, 2'b10, 1'b0, lat);
    chk("write_latency", lat, 5);
    get_txn(t);
    check_cpu("write_be10", t, 14'h0000, 1'b1, 2'b10);

    // Refresh wrap, video and CPU all on one clock: refresh, then video, then CPU.
    repeat (4) @(negedge clk);
    drain();
    scroll = 8'h05;
    while (((cyc + 1) % RP) != 0) @(negedge clk);
    a = 14'h2ABC;
    cpu_access(a, 1'b0, 2'b00, 1'b1, lat);
    chk("arb_cpu_latency", lat, 17);
    @(negedge clk);
    chk("arb_txn_count", txq.size(), 3);
    if (txq.size() == 3) begin
      t = txq.pop_front();
      t1 = txq.pop_front();
      t2 = txq.pop_front();
      chk("arb_first_is_refresh", {t.ack, t.load, t.cas}, {1'b0, 1'b0, 2'b11});
      check_ref(t);
      chk("arb_second_is_video", {t1.ack, t1.load}, 2'b01);
      check_vid("arb_video", t1, va);
      chk("arb_video_addr", va, 14'h20A0);
      check_cpu("arb_cpu", t2, a, 1'b0, 2'b00);
    end

    // CPU request withdrawn before its grant is never serviced.
    repeat (2) @(negedge clk);
    c0 = ack_cnt;
    cpu_addr = 14'h0777;
    cpu_req = 1'b1;
    pulse_vid();
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (15) @(negedge clk);
    chk("cancel_no_ack", ack_cnt - c0, 0);
    get_txn(t);
    check_vid("cancel_video", t, va);

    // Scrolled screen: 33 sequential words cross into the next line.
    repeat (2) @(negedge clk);
    scroll = 8'o330;
    pulse_frame();
    for (int i = 0; i < 33; i++) begin
      pulse_vid();
      get_txn(t);
      check_vid("scroll_word", t, va);
      if (i == 0)  chk("scroll_first_addr", {t.col, t.row}, 14'h3B00);
      if (i == 32) chk("scroll_last_addr", {t.col, t.row}, 14'h3B20);
      repeat (2) @(negedge clk);
    end

    // Overrun: second request during the first video cycle is dropped and flagged.
    pulse_frame();
    chk("ovr_clear_before", vid_ovr, 1'b0);
    c0 = load_cnt;
    pulse_vid();
    @(negedge clk);
    pulse_vid();
    repeat (20) @(negedge clk);
    chk("ovr_flag_set", vid_ovr, 1'b1);
    chk("ovr_single_load", load_cnt - c0, 1);
    get_txn(t);
    check_vid("ovr_video", t, va);
    drain();
    pulse_frame();
    chk("ovr_cleared_by_frame", vid_ovr, 1'b0);

    // Randomized CPU traffic, sometimes with a simultaneous video request.
    for (int i = 0; i < 24; i++) begin
      a = 14'($urandom);
      we = 1'($urandom_range(0, 1));
      be = 2'($urandom_range(0, 3));
      wv = ($urandom_range(0, 3) == 0);
      if (wv) scroll = 8'($urandom);
      cpu_access(a, we, be, wv, lat);
      if (wv) begin
        get_txn(t);
        check_vid("rand_video", t, va);
      end
      get_txn(t);
      check_cpu("rand_cpu", t, a, we, be);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset asserted in the CAS state of a CPU write.
    repeat (8) @(negedge clk);
    drain();
    cpu_addr = 14'h1555;
    cpu_we = 1'b1;
    cpu_be = 2'b11;
    cpu_req = 1'b1;
    n = 0;
    while (dram_cas_n !== 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_cas", dram_cas_n, 2'b00);
    c0 = ack_cnt;
    #1 rst = 1'b1;
    #1;
    chk("rst_async_strobes", {dram_ras_n, dram_cas_n, dram_we_n, cpu_ack},
        {1'b1, 2'b11, 1'b1, 1'b0});
    @(negedge clk);
    cpu_req = 1'b0;
    drain();
    exp_ref = '0;
    m_line = '0;
    m_word = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_ack", ack_cnt - c0, 0);
    chk("rst_no_txn", txq.size(), 0);
    cpu_access(14'h2E5A, 1'b0, 2'b01, 1'b0, lat);
    chk("post_rst_latency", lat, 5);
    get_txn(t);
    check_cpu("post_rst_read", t, 14'h2E5A, 1'b0, 2'b01);

    repeat (10) @(negedge clk);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
